nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Sequential front-end that accepts WIDTH-bit operands over a valid/ready handshake.
- Feeds them 4 bits per clock into a single 4-bit carry-select adder slice, carrying the nibble carry between cycles.
- Returns the full WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits directly upstream of the 4-bit carry-select adder and consumes its sum/carry each cycle. It trades latency for area against a fully parallel wide adder.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived local constant; number of slice iterations; not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, cin valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- **Reset**
  - Synchronous: sampled only on rising clk; reset has priority over every other event.
  - Reset values: state=IDLE; sum=0; cout=0; out_valid=0; busy=0; nibble index=0; internal carry=0.
  - in_ready = (state==IDLE) && !reset, so it is 0 in any cycle where reset is high.
- **States:** IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - On an edge with in_valid && in_ready: latch a, b into shift registers; carry←cin; idx←0; go to RUN.
  - Otherwise hold.
- **RUN**
  - in_ready=0, busy=1.
  - Each edge: the slice adds a_sh[3:0] + b_sh[3:0] with the internal carry.
    - The slice sum nibble shifts into sum from the MSB end.
    - carry←slice carry-out.
    - a_sh and b_sh shift right by 4.
    - idx←idx+1.
  - On the edge that processes idx==NIBBLES-1: cout←slice carry-out; go to DONE.
- **DONE**
  - out_valid=1, busy=1; sum and cout are held stable.
  - On an edge with out_ready=1: out_valid←0; go to IDLE.
  - out_ready low stalls indefinitely with no change to outputs.
- **Latency and throughput**
  - out_valid rises exactly NIBBLES cycles after the accepting edge (4 for WIDTH=16).
  - Minimum issue interval is NIBBLES+2 cycles, with out_ready tied high.
  - No overlap: a new operand is never accepted while busy.
- **Input rules**
  - a, b, cin, in_valid are ignored outside IDLE; changes during RUN/DONE do not affect the in-flight result.
- **Width rules**
  - Result is exact (WIDTH+1)-bit {cout,sum}.
  - No overflow flag; wrap-around is the consumer's concern.
  - idx is clog2(NIBBLES) bits wide, minimum 1.
- **Boundary cases**
  - WIDTH=4: one RUN cycle.
  - All-ones + cin=1: carry propagates through every nibble; sum=0, cout=1.
  - Reset in RUN or DONE aborts the operation. No out_valid pulse for the aborted operation. in_ready is 1 on the first cycle after reset deasserts.
  - out_ready high while out_valid is low has no effect.

Decomposition:
- Shared header/package adder_defs:
  - NIBBLE_W=4.
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - clog2 helper function.
- One sub-module: the existing 4-bit carry-select adder (carrySelectAdder4bit), instanced once.
  - Inputs: a_sh[3:0], b_sh[3:0], internal carry.
  - Outputs: slice sum nibble and carry.
- FSM, shift registers and handshake logic live in nibble_serial_adder.

Test Plan:
- WIDTH=16; a=16'h1234, b=16'h4321, cin=0, accepted at edge T → out_valid high after edge T+4; sum=16'h5555, cout=0.
- a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1. Also a=16'h8000, b=16'h8000, cin=0 → sum=16'h0000, cout=1.
- Result a=16'h00FF, b=16'h0001 → sum=16'h0100; hold out_ready=0 for 6 cycles. Required:
  - sum and cout stable, out_valid=1, in_ready=0.
  - A new in_valid with a=16'h1111 is not accepted.
  - One cycle after out_ready=1, in_ready=1.
- Assert reset for one cycle when idx==2 of a=16'hABCD, b=16'h1111. Required:
  - Next cycle state IDLE, out_valid=0, sum=0, busy=0.
  - A following operation a=16'h0001, b=16'h0001 yields 16'h0002.
- in_valid and out_ready tied high, a/b toggled every cycle during RUN:
  - Accepts spaced exactly 6 cycles apart.
  - Each result matches the operands latched at its own accepting edge.
- 1000 random a, b, cin with random out_ready backpressure, on WIDTH=16 and WIDTH=4 builds → {cout,sum} == a+b+cin for every result; no dropped or duplicated results.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM encoding
// and a width helper for the nibble index counter.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ceiling log2, never less than 1 so a single-nibble build still has an index bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshakes of the nibble-serial adder; the producer/consumer
// side uses the master modport, the adder uses the slave modport.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/nibble_serial_adder_csa.sv
// 4-bit carry-select adder slice: the low pair ripples from cin, the high pair is
// precomputed for both carries and selected by the low-pair carry.
module carrySelectAdder4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;

    assign lo   = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    assign hi0  = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign hi1  = hi0 + 3'd1;
    assign sum  = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
    assign cout = lo[2] ? hi1[2] : hi0[2];
endmodule

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit carry-select slice is reused for NIBBLES
// cycles, LSB nibble first, with the nibble carry held between cycles.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    nibble_serial_adder_if.slave  bus,
    output logic                  busy
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             cout_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] a_sh_d;
    logic [WIDTH-1:0] b_sh_d;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    carrySelectAdder4bit u_slice (
        .a    (a_sh_q[NIBBLE_W-1:0]),
        .b    (b_sh_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Each slice result enters at the MSB end, so after NIBBLES shifts nibble 0 sits at the LSB.
    always_comb begin
        sum_d  = (sum_q >> NIBBLE_W) | (WIDTH'(slice_sum) << (WIDTH - NIBBLE_W));
        a_sh_d = a_sh_q >> NIBBLE_W;
        b_sh_d = b_sh_q >> NIBBLE_W;
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sum_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= slice_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: operand shift registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && bus.in_valid && !reset) begin
            a_sh_q <= bus.a;
            b_sh_q <= bus.b;
        end else if (state_q == ST_RUN) begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE) && !reset;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder at WIDTH=16 and WIDTH=4,
// with a scoreboard of expected {cout,sum} filled at every accepting edge.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    logic reset;
    logic busy16;
    logic busy4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pushed16 = 0;
    int pushed4  = 0;
    int got16    = 0;
    int got4     = 0;

    logic [16:0] sb16[$];
    logic [4:0]  sb4[$];
    int          acc16[$];

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
    nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16),
        .busy  (busy16)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4),
        .busy  (busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Called just after a falling edge: inputs are set, outputs are stable, so the
    // handshakes that will complete on the coming rising edge are known here.
    task automatic tick();
        logic [16:0] e16;
        logic [4:0]  e4;
        if (reset) begin
            sb16.delete();
            sb4.delete();
        end else begin
            if (bus16.in_valid && bus16.in_ready) begin
                sb16.push_back(17'(bus16.a) + 17'(bus16.b) + 17'(bus16.cin));
                acc16.push_back(cyc);
                pushed16++;
            end
            if (bus16.out_valid && bus16.out_ready) begin
                got16++;
                check("sb16_pending", 32'(sb16.size() > 0), 32'd1);
                if (sb16.size() > 0) begin
                    e16 = sb16.pop_front();
                    check("sb16_result", 32'({bus16.cout, bus16.sum}), 32'(e16));
                end
            end
            if (bus4.in_valid && bus4.in_ready) begin
                sb4.push_back(5'(bus4.a) + 5'(bus4.b) + 5'(bus4.cin));
                pushed4++;
            end
            if (bus4.out_valid && bus4.out_ready) begin
                got4++;
                check("sb4_pending", 32'(sb4.size() > 0), 32'd1);
                if (sb4.size() > 0) begin
                    e4 = sb4.pop_front();
                    check("sb4_result", 32'({bus4.cout, bus4.sum}), 32'(e4));
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_out16(output int lat);
        lat = 0;
        while (!bus16.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("out_valid16_timeout", 32'(bus16.out_valid), 32'd1);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin, input string tag);
        int lat;
        bus16.a        = a;
        bus16.b        = b;
        bus16.cin      = cin;
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        wait_out16(lat);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;
        check({tag, "_drained"}, 32'(sb16.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int p;

        reset           = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.cin       = 1'b0;
        bus16.out_ready = 1'b0;
        bus4.in_valid   = 1'b0;
        bus4.a          = '0;
        bus4.b          = '0;
        bus4.cin        = 1'b0;
        bus4.out_ready  = 1'b0;

        @(negedge clk);
        tick();
        tick();
        check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        check("rst_sum", 32'(bus16.sum), 32'd0);
        check("rst_cout", 32'(bus16.cout), 32'd0);
        check("rst_busy", 32'(busy16), 32'd0);
        check("rst_in_ready_low", 32'(bus16.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready_high", 32'(bus16.in_ready), 32'd1);

        // out_ready while idle does nothing
        bus16.out_ready = 1'b1;
        tick();
        tick();
        bus16.out_ready = 1'b0;
        check("idle_ready_out_valid", 32'(bus16.out_valid), 32'd0);
        check("idle_ready_busy", 32'(busy16), 32'd0);
        check("idle_ready_in_ready", 32'(bus16.in_ready), 32'd1);

        // 1234 + 4321
        bus16.a        = 16'h1234;
        bus16.b        = 16'h4321;
        bus16.cin      = 1'b0;
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        check("t1_busy", 32'(busy16), 32'd1);
        check("t1_in_ready", 32'(bus16.in_ready), 32'd0);
        wait_out16(lat);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_sum", 32'(bus16.sum), 32'h5555);
        check("t1_cout", 32'(bus16.cout), 32'd0);
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;
        check("t1_released_in_ready", 32'(bus16.in_ready), 32'd1);
        check("t1_released_busy", 32'(busy16), 32'd0);

        run16(16'hFFFF, 16'h0000, 1'b1, "all_ones_cin");
        run16(16'h8000, 16'h8000, 1'b0, "msb_carry");

        // Backpressure stall
        bus16.a        = 16'h00FF;
        bus16.b        = 16'h0001;
        bus16.cin      = 1'b0;
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        wait_out16(lat);
        p = pushed16;
        bus16.a        = 16'h1111;
        bus16.b        = 16'h0000;
        bus16.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stall_out_valid", 32'(bus16.out_valid), 32'd1);
            check("stall_in_ready", 32'(bus16.in_ready), 32'd0);
            check("stall_sum", 32'(bus16.sum), 32'h0100);
            check("stall_cout", 32'(bus16.cout), 32'd0);
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;
        check("stall_release_in_ready", 32'(bus16.in_ready), 32'd1);
        check("stall_no_accept", 32'(pushed16 - p), 32'd0);
        check("stall_drained", 32'(sb16.size()), 32'd0);

        // Reset aborts an operation at idx==2
        bus16.a        = 16'hABCD;
        bus16.b        = 16'h1111;
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus16.out_valid), 32'd0);
        check("abort_sum", 32'(bus16.sum), 32'd0);
        check("abort_busy", 32'(busy16), 32'd0);
        check("abort_in_ready", 32'(bus16.in_ready), 32'd1);
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_pulse", 32'(bus16.out_valid), 32'd0);
        end
        bus16.out_ready = 1'b0;
        run16(16'h0001, 16'h0001, 1'b0, "after_abort");

        // Back-to-back issue with operands changing every cycle
        acc16.delete();
        bus16.in_valid  = 1'b1;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            bus16.a   = 16'($urandom);
            bus16.b   = 16'($urandom);
            bus16.cin = 1'($urandom);
            tick();
        end
        bus16.in_valid = 1'b0;
        for (int i = 0; i < 20 && busy16; i++) tick();
        bus16.out_ready = 1'b0;
        check("b2b_accepts", 32'(acc16.size()), 32'd4);
        for (int i = 1; i < acc16.size(); i++)
            check("b2b_spacing", 32'(acc16[i] - acc16[i-1]), 32'd6);
        check("b2b_drained", 32'(sb16.size()), 32'd0);
        check("b2b_idle", 32'(busy16), 32'd0);

        // Random operands with random backpressure on both widths
        pushed16 = 0;
        pushed4  = 0;
        got16    = 0;
        got4     = 0;
        for (int c = 0; c < 40000 && (got16 < 1000 || got4 < 1000); c++) begin
            bus16.in_valid  = (pushed16 < 1000) && ($urandom_range(0, 3) != 0);
            bus16.a         = 16'($urandom);
            bus16.b         = 16'($urandom);
            bus16.cin       = 1'($urandom);
            bus16.out_ready = 1'($urandom_range(0, 1));
            bus4.in_valid   = (pushed4 < 1000) && ($urandom_range(0, 3) != 0);
            bus4.a          = 4'($urandom);
            bus4.b          = 4'($urandom);
            bus4.cin        = 1'($urandom);
            bus4.out_ready  = 1'($urandom_range(0, 1));
            tick();
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b0;
        bus4.in_valid   = 1'b0;
        bus4.out_ready  = 1'b0;
        check("rand16_pushed", 32'(pushed16), 32'd1000);
        check("rand16_got", 32'(got16), 32'd1000);
        check("rand16_drained", 32'(sb16.size()), 32'd0);
        check("rand4_pushed", 32'(pushed4), 32'd1000);
        check("rand4_got", 32'(got4), 32'd1000);
        check("rand4_drained", 32'(sb4.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
